// File: rtl/rf_read_port_if.sv
// rf_read_port_if: read request / response handshake between decode and the read port
interface rf_read_port_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ack;
  modport slave  (input rd_req, rd_addr, rd_ack, output rd_ready, rd_valid, rd_data);
  modport master (output rd_req, rd_addr, rd_ack, input rd_ready, rd_valid, rd_data);
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one-hot bitline read of the register array with write bypass and R0-reads-zero
module rf_read_port #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  rf_read_port_if.slave       rd,
  output logic [NUM_REGS-1:0] read_en,
  input  logic [DATA_W-1:0]   bitline,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data
);
  typedef enum logic [1:0] {IDLE, DRIVE, VALID} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic accept, hit, zero;
  assign zero        = addr_q == '0;
  assign hit         = wr_en && wr_addr == addr_q;
  assign rd.rd_ready = state == IDLE || (state == VALID && rd.rd_ack);
  assign rd.rd_valid = state == VALID;
  assign rd.rd_data  = data_q;
  assign accept      = rd.rd_ready && rd.rd_req;
  // Decoded from state so an async reset removes the bitline driver immediately.
  assign read_en = (state == DRIVE && !zero) ? NUM_REGS'(1) << addr_q : '0;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? DRIVE : IDLE;
      DRIVE:   next = VALID;
      VALID:   next = rd.rd_ack ? (rd.rd_req ? DRIVE : IDLE) : VALID;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= next;
      if (accept) addr_q <= rd.rd_addr;
      if (state == DRIVE) data_q <= zero ? '0 : hit ? wr_data : bitline;
      else if (state == VALID && !rd.rd_ack && hit && !zero) data_q <= wr_data;
    end
  end
endmodule
